// File: rtl/mdio_phy_responder_pkg.sv
// Shared MDIO Clause-22 frame constants and responder FSM encoding.
// Field indices count mdc rising edges from the first ST bit (edge 0).
package mdio_phy_responder_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam logic [4:0] BIT_HDR_START = 5'd2;
  localparam logic [4:0] BIT_REGAD_END = 5'd13;
  localparam logic [4:0] BIT_TA_END    = 5'd15;
  localparam logic [4:0] BIT_LAST      = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_TA_WR,
    S_DATA_WR,
    S_TA_RD,
    S_DATA_RD,
    S_SKIP
  } mdio_state_t;

endpackage

// File: rtl/mdio_phy_responder_edge_det.sv
// mdc synchroniser stage: one register on clk plus rise/fall pulses.
// Pulses are combinational and last until the next clk edge.
module mdio_mdc_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_mdc,
  output logic o_rise,
  output logic o_fall
);

  logic r_mdc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mdc_q <= 1'b0;
    end else begin
      r_mdc_q <= i_mdc;
    end
  end

  assign o_rise = i_mdc & ~r_mdc_q;
  assign o_fall = ~i_mdc & r_mdc_q;

endmodule

// File: rtl/mdio_phy_responder.sv
// PHY-side Clause-22 MDIO responder fronting a 32x16 register strobe port.
// Define MDIO_TA_CHECK_EN to reject write frames whose TA is not 2'b10.
module mdio_phy_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  output logic        mdio_in,
  output logic [4:0]  reg_addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        rd_stb,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic        frame_err
);

  import mdio_phy_responder_pkg::*;

  mdio_state_t r_state;
  logic [4:0]  r_cnt;
  logic [15:0] r_sh;
  logic [15:0] r_tx;
  logic        r_pv;
  logic        r_cap;
  logic        r_busy;
  logic        r_mdio_in;
  logic [4:0]  r_reg_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_stb;
  logic        r_rd_stb;
  logic        r_ferr;

  logic        w_rise;
  logic        w_unused_fall;
  logic [15:0] w_sh_n;
  logic [1:0]  w_op;
  logic [4:0]  w_phy;
  logic [4:0]  w_reg;
  logic        w_match;
  logic        w_last;
  logic        w_wr_path;
  logic        w_abort;

  mdio_mdc_edge_det u_edge (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_mdc   (mdc),
    .o_rise  (w_rise),
    .o_fall  (w_unused_fall)
  );

  assign w_sh_n  = {r_sh[14:0], mdio_out};
  assign w_op    = w_sh_n[11:10];
  assign w_phy   = w_sh_n[9:5];
  assign w_reg   = w_sh_n[4:0];
  assign w_match = (w_phy == PHY_ADDR);
  assign w_last  = (r_cnt == BIT_LAST);

  // The generator owns the bus through header and write data only
  assign w_wr_path = (r_state == S_HDR)
                   | (r_state == S_TA_WR)
                   | (r_state == S_DATA_WR);
  assign w_abort   = w_rise & ~mdio_oe & w_wr_path;

`ifdef MDIO_TA_CHECK_EN
  logic w_ta_ok;
  assign w_ta_ok = (w_sh_n[1:0] == MDIO_TA_WR);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_sh       <= 16'h0;
      r_tx       <= 16'h0;
      r_pv       <= 1'b0;
      r_cap      <= 1'b0;
      r_busy     <= 1'b0;
      r_mdio_in  <= 1'b0;
      r_reg_addr <= 5'd0;
      r_wr_data  <= 16'h0;
      r_wr_stb   <= 1'b0;
      r_rd_stb   <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
      r_ferr   <= 1'b0;
      r_cap    <= r_rd_stb;
      if (r_cap) begin
        r_tx <= rd_data;
      end
      if (w_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_pv    <= 1'b0;
`ifdef MDIO_TA_CHECK_EN
        r_ferr  <= 1'b1;
`endif
      end else if (w_rise) begin
        unique case (r_state)
          S_IDLE: begin
            if (mdio_oe) begin
              r_sh <= w_sh_n;
              r_pv <= 1'b1;
              // r_pv keeps a stale reset-zero from faking ST
              if (r_pv && (w_sh_n[1:0] == MDIO_ST)) begin
                r_busy  <= 1'b1;
                r_cnt   <= BIT_HDR_START;
                r_state <= S_HDR;
              end
            end else begin
              r_pv <= 1'b0;
            end
          end
          S_HDR: begin
            r_sh  <= w_sh_n;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == BIT_REGAD_END) begin
              r_reg_addr <= w_reg;
              if (w_match && (w_op == MDIO_OP_WR)) begin
                r_state <= S_TA_WR;
              end else if (w_match && (w_op == MDIO_OP_RD)) begin
                r_rd_stb <= 1'b1;
                r_state  <= S_TA_RD;
              end else begin
                r_state <= S_SKIP;
              end
            end
          end
          S_TA_WR: begin
            r_sh  <= w_sh_n;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == BIT_TA_END) begin
`ifdef MDIO_TA_CHECK_EN
              if (w_ta_ok) begin
                r_state <= S_DATA_WR;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= S_SKIP;
              end
`else
              r_state <= S_DATA_WR;
`endif
            end
          end
          S_DATA_WR: begin
            r_sh  <= w_sh_n;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
              r_wr_data <= w_sh_n;
              r_wr_stb  <= 1'b1;
              r_busy    <= 1'b0;
              r_pv      <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
          S_TA_RD: begin
            r_cnt     <= r_cnt + 5'd1;
            r_mdio_in <= 1'b0;
            if (r_cnt == BIT_TA_END) begin
              r_mdio_in <= r_tx[15];
              r_tx      <= {r_tx[14:0], 1'b0};
              r_state   <= S_DATA_RD;
            end
          end
          S_DATA_RD: begin
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
              r_mdio_in <= 1'b0;
              r_busy    <= 1'b0;
              r_pv      <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_mdio_in <= r_tx[15];
              r_tx      <= {r_tx[14:0], 1'b0};
            end
          end
          S_SKIP: begin
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_pv    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign mdio_in   = r_mdio_in;
  assign reg_addr  = r_reg_addr;
  assign wr_data   = r_wr_data;
  assign wr_stb    = r_wr_stb;
  assign rd_stb    = r_rd_stb;
  assign busy      = r_busy;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench for mdio_phy_responder: driver queues expected strobes,
// a negedge monitor pops and compares each strobe the DUT raises.
`timescale 1ns/1ps
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        rd_stb;
  logic [15:0] rd_data;
  logic        busy;
  logic        frame_err;

  logic [15:0] rd_val;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  mdio_phy_responder #(.PHY_ADDR(5'h15)) dut (
    .clk       (clk),
    .reset     (reset),
    .mdc       (mdc),
    .mdio_out  (mdio_out),
    .mdio_oe   (mdio_oe),
    .mdio_in   (mdio_in),
    .reg_addr  (reg_addr),
    .wr_data   (wr_data),
    .wr_stb    (wr_stb),
    .rd_stb    (rd_stb),
    .rd_data   (rd_data),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Register file stand-in: data valid only the clk after rd_stb
  always @(posedge clk) begin
    rd_data <= rd_stb ? rd_val : 16'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [4:0] a,
                      input logic [15:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && (wr_stb || rd_stb || frame_err)) begin
      ev_t g;
      ev_t e;
      g.kind = wr_stb ? 0 : (rd_stb ? 1 : 2);
      g.addr = reg_addr;
      g.data = wr_stb ? wr_data : 16'h0;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: got kind %0d addr %h data %h expected none",
                 g.kind, g.addr, g.data);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", g.kind, e.kind);
        chk("strobe_addr", {27'd0, g.addr}, {27'd0, e.addr});
        if (e.kind == 0) chk("wr_data", {16'd0, g.data}, {16'd0, e.data});
      end
    end
  end

  task automatic drive_edge(input logic b, input logic oe,
                            input logic ei, output logic bz);
    @(negedge clk);
    mdc = 1'b0;
    mdio_out = oe ? b : 1'b0;
    mdio_oe = oe;
    repeat (3) @(negedge clk);
    mdc = 1'b1;
    chk("mdio_in", {31'd0, mdio_in}, {31'd0, ei});
    bz = busy;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] f, input logic [31:0] oem,
                            input logic rd, input logic [15:0] rv,
                            input int rst_k, input int exp_bz);
    int   nb;
    logic bz;
    logic live;
    logic ei;
    nb = 0;
    live = rd;
    rd_val = rv;
    for (int k = 0; k < 32; k++) begin
      ei = 1'b0;
      if (live && k >= 16) ei = rv[31-k];
      drive_edge(f[31-k], oem[31-k], ei, bz);
      if (bz) nb++;
      if (k == rst_k) begin
        reset = 1'b0;
        #1;
        chk("reset_mid_frame",
            {6'd0, busy, mdio_in, reg_addr, wr_data, wr_stb, rd_stb, frame_err},
            32'd0);
        live = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    mdc = 1'b0;
    mdio_oe = 1'b0;
    mdio_out = 1'b0;
    repeat (4) @(negedge clk);
    if (exp_bz >= 0) chk("busy_edges", nb, exp_bz);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_mdio_in", {31'd0, mdio_in}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bz;
    reset = 1'b0;
    mdc = 1'b0;
    mdio_out = 1'b0;
    mdio_oe = 1'b0;
    rd_val = 16'h0;
    repeat (5) @(negedge clk);
    chk("reset_outs",
        {6'd0, busy, mdio_in, reg_addr, wr_data, wr_stb, rd_stb, frame_err},
        32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // write, TA=10, REGAD 0E, data 7654
    push(0, 5'h0E, 16'h7654);
    send_frame(32'h5ABA7654, 32'hFFFFFFFF, 1'b0, 16'h0, -1, 30);

    // 5AB97654 carries TA=01
`ifdef MDIO_TA_CHECK_EN
    push(2, 5'h0E, 16'h0);
`else
    push(0, 5'h0E, 16'h7654);
`endif
    send_frame(32'h5AB97654, 32'hFFFFFFFF, 1'b0, 16'h0, -1, 30);

    // read REGAD 0E, bus released from TA on
    push(1, 5'h0E, 16'h0);
    send_frame(32'h6AB80000, 32'hFFFC0000, 1'b1, 16'hA5C3, -1, 30);

    // PHYAD 14 mismatch: nothing but busy
    send_frame(32'h5A397654, 32'hFFFFFFFF, 1'b0, 16'h0, -1, 30);

    // preamble, then two back-to-back writes
    for (int i = 0; i < 32; i++) begin
      drive_edge(1'b1, 1'b1, 1'b0, bz);
      chk("preamble_busy", {31'd0, bz}, 32'd0);
    end
    push(0, 5'h0E, 16'h7654);
    send_frame(32'h5ABA7654, 32'hFFFFFFFF, 1'b0, 16'h0, -1, 30);
    push(0, 5'h03, 16'hBEEF);
    send_frame(32'h5A8EBEEF, 32'hFFFFFFFF, 1'b0, 16'h0, -1, 30);

    // mdio_oe dropped at edge 20 of a write
`ifdef MDIO_TA_CHECK_EN
    push(2, 5'h0E, 16'h0);
`endif
    send_frame(32'h5ABA7654, 32'hFFFFF000, 1'b0, 16'h0, -1, -1);

    // reset asserted at edge 20 of a read
    push(1, 5'h0E, 16'h0);
    send_frame(32'h6AB80000, 32'hFFFC0000, 1'b1, 16'hA5C3, 20, -1);

    // write with TA=11
`ifdef MDIO_TA_CHECK_EN
    push(2, 5'h0E, 16'h0);
`else
    push(0, 5'h0E, 16'h7654);
`endif
    send_frame(32'h5ABB7654, 32'hFFFFFFFF, 1'b0, 16'h0, -1, 30);

    // read REGAD 03 after recovery
    push(1, 5'h03, 16'h0);
    send_frame(32'h6A8C0000, 32'hFFFC0000, 1'b1, 16'h1234, -1, 30);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
